// File: rtl/reg_acc_arbiter.sv
// Round-robin arbiter sharing one register-slave port between NUM_MST requesters.
// Optional WAIT-state timeout with error response is enabled by defining REG_ARB_TIMEOUT_EN.
module reg_acc_arbiter #(
    parameter int NUM_MST        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_MST-1:0]            mst_req_vld,
    input  logic [NUM_MST-1:0]            mst_wr_en,
    input  logic [NUM_MST-1:0]            mst_rd_en,
    input  logic [NUM_MST*ADDR_WIDTH-1:0] mst_addr,
    input  logic [NUM_MST*DATA_WIDTH-1:0] mst_wr_data,
    output logic [NUM_MST-1:0]            mst_ack_vld,
    output logic [NUM_MST-1:0]            mst_err,
    output logic [DATA_WIDTH-1:0]         mst_rd_data,
    output logic                          slv_req_vld,
    output logic                          slv_wr_en,
    output logic                          slv_rd_en,
    output logic [ADDR_WIDTH-1:0]         slv_addr,
    output logic [DATA_WIDTH-1:0]         slv_wr_data,
    input  logic                          slv_ack_vld,
    input  logic [DATA_WIDTH-1:0]         slv_rd_data
);

    localparam int GW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [GW-1:0]           gnt_r, gnt_nxt_s;
    logic [GW-1:0]           last_gnt_r, last_gnt_nxt_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_nxt_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_nxt_s;
    logic [DATA_WIDTH-1:0]   rdata_r, rdata_nxt_s;
    logic                    wr_en_r, wr_en_nxt_s;
    logic                    rd_en_r, rd_en_nxt_s;
    logic                    slv_req_r, slv_req_nxt_s;
    logic [NUM_MST-1:0]      ack_r, ack_nxt_s;
    logic [NUM_MST-1:0]      err_r, err_nxt_s;
    logic [GW:0]             pick_s;
    logic                    pick_vld_s;
    logic [GW-1:0]           pick_idx_s;
    logic                    pick_cmd_s;
    logic                    timeout_s;

    // First requester found scanning upward from last+1, wrapping; MSB flags a hit.
    function automatic logic [GW:0] rr_pick(input logic [NUM_MST-1:0] req,
                                            input logic [GW-1:0]      last);
        logic [GW:0]   res;
        int unsigned   idx;
        logic [GW-1:0] idx_g;
        res = '0;
        for (int unsigned k = 1; k <= NUM_MST; k++) begin
            idx   = (32'(last) + k) % NUM_MST;
            idx_g = GW'(idx);
            if (!res[GW] && req[idx_g]) begin
                res = {1'b1, idx_g};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_MST-1:0] onehot(input logic [GW-1:0] i);
        logic [NUM_MST-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign pick_s     = rr_pick(mst_req_vld, last_gnt_r);
    assign pick_vld_s = pick_s[GW];
    assign pick_idx_s = pick_s[GW-1:0];
    assign pick_cmd_s = mst_wr_en[pick_idx_s] | mst_rd_en[pick_idx_s];

`ifdef REG_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_r;

    assign timeout_s = (state_r == WAIT) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // WAIT-cycle counter; cleared whenever WAIT is not continuing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == WAIT) && !slv_ack_vld && !timeout_s) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-value logic for every registered output and capture register.
    always_comb begin
        state_nxt_s    = state_r;
        gnt_nxt_s      = gnt_r;
        last_gnt_nxt_s = last_gnt_r;
        addr_nxt_s     = addr_r;
        wdata_nxt_s    = wdata_r;
        rdata_nxt_s    = rdata_r;
        wr_en_nxt_s    = wr_en_r;
        rd_en_nxt_s    = rd_en_r;
        slv_req_nxt_s  = 1'b0;
        ack_nxt_s      = '0;
        err_nxt_s      = '0;
        case (state_r)
            IDLE: begin
                if (pick_vld_s) begin
                    gnt_nxt_s   = pick_idx_s;
                    addr_nxt_s  = mst_addr[pick_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_nxt_s = mst_wr_data[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    wr_en_nxt_s = mst_wr_en[pick_idx_s];
                    // Write wins a conflicting command.
                    rd_en_nxt_s = mst_rd_en[pick_idx_s] & ~mst_wr_en[pick_idx_s];
                    if (pick_cmd_s) begin
                        state_nxt_s   = ISSUE;
                        slv_req_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = RESP;
                        ack_nxt_s   = onehot(pick_idx_s);
                        rdata_nxt_s = '0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (slv_ack_vld) begin
                    state_nxt_s = RESP;
                    rdata_nxt_s = slv_rd_data;
                    ack_nxt_s   = onehot(gnt_r);
                end else if (timeout_s) begin
                    state_nxt_s = RESP;
                    rdata_nxt_s = '0;
                    ack_nxt_s   = onehot(gnt_r);
                    err_nxt_s   = onehot(gnt_r);
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                last_gnt_nxt_s = gnt_r;
                state_nxt_s    = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            gnt_r      <= '0;
            last_gnt_r <= GW'(NUM_MST - 1);
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
            wr_en_r    <= 1'b0;
            rd_en_r    <= 1'b0;
            slv_req_r  <= 1'b0;
            ack_r      <= '0;
            err_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            gnt_r      <= gnt_nxt_s;
            last_gnt_r <= last_gnt_nxt_s;
            addr_r     <= addr_nxt_s;
            wdata_r    <= wdata_nxt_s;
            rdata_r    <= rdata_nxt_s;
            wr_en_r    <= wr_en_nxt_s;
            rd_en_r    <= rd_en_nxt_s;
            slv_req_r  <= slv_req_nxt_s;
            ack_r      <= ack_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    assign mst_ack_vld = ack_r;
    assign mst_err     = err_r;
    assign mst_rd_data = rdata_r;
    assign slv_req_vld = slv_req_r;
    assign slv_wr_en   = wr_en_r;
    assign slv_rd_en   = rd_en_r;
    assign slv_addr    = addr_r;
    assign slv_wr_data = wdata_r;

endmodule
